inst_rom_loader: RTL and testbench

INST_ROM_LOADER -- requirements
Module: inst_rom_loader

---
 rtl/inst_rom_loader_pkg.sv | 12 +
 rtl/rom_word_array.sv | 18 +
 rtl/inst_rom_loader.sv | 95 +++++++++
 tb/tb_inst_rom_loader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// inst_rom_loader_pkg: shared FSM encoding and boot count width for the boot ROM loader.
package inst_rom_loader_pkg;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_RUN    = 3'd4
    } state_t;
endpackage

// File: rtl/rom_word_array.sv
// rom_word_array: 2^ADDR_W x 32 storage, one synchronous write port, one combinational read port.
module rom_word_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);
    logic [31:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction ROM that is filled from a byte stream (length then big-endian words)
// while holding the CPU in reset, then serves combinational fetches.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_data_i,
    output logic              ld_ready_o,
    output logic              cpu_rst_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   words_loaded_o
);
    localparam int DEPTH = 2**ADDR_W;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, r_word_idx;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_shift;
    logic [ADDR_W:0]  r_words;
    logic             w_acc, w_word_end, w_last, w_in_range, w_we, w_start;
    logic [31:0]      w_rdata;

    assign w_acc      = ld_valid_i && ld_ready_o;
    assign w_word_end = w_acc && r_state == S_DATA && r_byte_idx == 2'd3;
    assign w_last     = r_word_idx == r_cnt - 16'd1;
    assign w_in_range = 32'(r_word_idx) < DEPTH;
    assign w_we       = w_word_end && w_in_range;
    assign w_start    = ld_start_i && (r_state == S_IDLE || r_state == S_RUN);

    rom_word_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_word_idx[ADDR_W-1:0]),
        .i_wdata ({r_shift, ld_data_i}),
        .i_raddr (rom_addr_i[ADDR_W+1:2]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = ld_start_i ? S_LEN_HI : S_IDLE;
            S_LEN_HI: w_next = w_acc ? S_LEN_LO : S_LEN_HI;
            S_LEN_LO: w_next = !w_acc ? S_LEN_LO : ({r_cnt[15:8], ld_data_i} == 16'd0) ? S_RUN : S_DATA;
            S_DATA:   w_next = (w_word_end && w_last) ? S_RUN : S_DATA;
            S_RUN:    w_next = ld_start_i ? S_LEN_HI : S_RUN;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready_o  = r_state == S_LEN_HI || r_state == S_LEN_LO || r_state == S_DATA;
        load_done_o = r_state == S_RUN;
        cpu_rst_o   = r_state != S_RUN;
        rom_data_o  = (rom_ce_i && load_done_o && rom_addr_i[31:ADDR_W+2] == '0) ? w_rdata : 32'd0;
    end

    // Words past the array end still advance the index so the stream stays framed.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_cnt      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_words    <= '0;
        end else begin
            if (w_start) r_words <= '0;
            if (w_acc && r_state == S_LEN_HI) r_cnt[15:8] <= ld_data_i;
            if (w_acc && r_state == S_LEN_LO) begin
                r_cnt[7:0] <= ld_data_i;
                r_word_idx <= '0;
                r_byte_idx <= '0;
            end
            if (w_acc && r_state == S_DATA) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_shift    <= {r_shift[15:0], ld_data_i};
                if (w_word_end) r_word_idx <= r_word_idx + 16'd1;
            end
            if (w_we) r_words <= r_words + 1'b1;
        end

    assign words_loaded_o = r_words;
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: drives a default-size and a 4-word loader from the same stimulus and
// checks load sequencing, fetch gating and overflow handling against bench-computed values.
module tb_inst_rom_loader;
    logic        clk = 0, rst = 0;
    logic        rom_ce = 0, ld_start = 0, ld_valid = 0;
    logic [31:0] rom_addr = 0;
    logic [7:0]  ld_data = 0;
    logic [31:0] rd1, rd2;
    logic        rdy1, rdy2, crst1, crst2, done1, done2;
    logic [10:0] wl1;
    logic [2:0]  wl2;
    int          n_cmp = 0, n_bad = 0;

    typedef struct { string nm; logic [31:0] e1; logic [31:0] e2; } sb_t;
    typedef struct { string nm; logic ce; logic [31:0] addr; logic [31:0] e1; logic [31:0] e2; } fv_t;
    sb_t  sb[$];
    fv_t  tbl[8];
    logic [7:0] bytes[$];

    always #5 clk = ~clk;

    inst_rom_loader dut (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rd1),
        .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_ready_o(rdy1),
        .cpu_rst_o(crst1), .load_done_o(done1), .words_loaded_o(wl1)
    );

    inst_rom_loader #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(rd2),
        .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_ready_o(rdy2),
        .cpu_rst_o(crst2), .load_done_o(done2), .words_loaded_o(wl2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic status(input string nm, input logic rdy, input logic crst, input logic done,
                          input int w1, input int w2);
        chk({nm, " ready"},   {31'd0, rdy1},  {31'd0, rdy});
        chk({nm, " cpu_rst"}, {31'd0, crst1}, {31'd0, crst});
        chk({nm, " done"},    {31'd0, done1}, {31'd0, done});
        chk({nm, " words"},   32'(wl1), 32'(w1));
        chk({nm, " ready2"},  {31'd0, rdy2},  {31'd0, rdy});
        chk({nm, " done2"},   {31'd0, done2}, {31'd0, done});
        chk({nm, " words2"},  32'(wl2), 32'(w2));
    endtask

    task automatic fetch(input string nm, input logic ce, input logic [31:0] a,
                         input logic [31:0] e1, input logic [31:0] e2);
        sb_t s;
        @(negedge clk);
        rom_ce = ce;
        rom_addr = a;
        sb.push_back('{nm, e1, e2});
        #1;
        s = sb.pop_front();
        chk({s.nm, " dut"}, rd1, s.e1);
        chk({s.nm, " dut2"}, rd2, s.e2);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        ld_start = 1;
        @(negedge clk);
        ld_start = 0;
    endtask

    // gap: idle cycles between bytes; pulse_at: byte index after which a stray ld_start is driven
    task automatic send(input int gap, input int pulse_at);
        for (int i = 0; i < bytes.size(); i++) begin
            @(negedge clk);
            ld_valid = 1;
            ld_data = bytes[i];
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                ld_valid = 0;
                ld_start = (i == pulse_at);
            end
            if (gap > 0) begin
                @(negedge clk);
                ld_start = 0;
            end
        end
        @(negedge clk);
        ld_valid = 0;
        ld_start = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) bytes.push_back(w[8*k +: 8]);
    endtask

    initial begin
        #1;
        status("reset", 0, 1, 0, 0, 0);
        chk("reset cpu_rst2", {31'd0, crst2}, 32'd1);
        fetch("reset fetch", 1, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        status("idle", 0, 1, 0, 0, 0);

        // basic two-word image
        start_pulse();
        status("len_hi", 1, 1, 0, 0, 0);
        bytes = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h10, 8'h34, 8'h02, 8'h00};
        send(0, -1);
        status("before last", 1, 1, 0, 1, 1);
        bytes = '{8'h20};
        send(0, -1);
        status("load2 done", 0, 0, 1, 2, 2);
        chk("load2 cpu_rst2", {31'd0, crst2}, 32'd0);
        tbl[0] = '{"w0",        1, 32'h0000_0000, 32'h3401_0010, 32'h3401_0010};
        tbl[1] = '{"w1",        1, 32'h0000_0004, 32'h3402_0020, 32'h3402_0020};
        tbl[2] = '{"ce off",    0, 32'h0000_0004, 32'h0,         32'h0};
        tbl[3] = '{"high addr", 1, 32'h1000_0000, 32'h0,         32'h0};
        tbl[4] = '{"addr 1000", 1, 32'h0000_1000, 32'h0,         32'h0};
        tbl[5] = '{"w1 byte3",  1, 32'h0000_0007, 32'h3402_0020, 32'h3402_0020};
        tbl[6] = '{"addr 10",   1, 32'h0000_0010, 32'h0,         32'h0};
        tbl[7] = '{"ce off w0", 0, 32'h0000_0000, 32'h0,         32'h0};
        for (int i = 0; i < 8; i++)
            if (i != 6) fetch(tbl[i].nm, tbl[i].ce, tbl[i].addr, tbl[i].e1, tbl[i].e2);

        // zero-length image: RUN after the two length bytes, memory kept
        start_pulse();
        status("restart", 1, 1, 0, 0, 0);
        fetch("fetch during load", 1, 32'h0, 32'h0, 32'h0);
        bytes = '{8'h00, 8'h00};
        send(0, -1);
        status("n0", 0, 0, 1, 0, 0);
        fetch("n0 keep w0", 1, 32'h0, 32'h3401_0010, 32'h3401_0010);

        // five words: dut2 holds only four and must not wrap
        start_pulse();
        bytes = '{8'h00, 8'h05};
        for (int i = 0; i < 5; i++) push_word(32'hA000_0000 + 32'(i * 32'h0101_0101));
        send(0, -1);
        status("n5", 0, 0, 1, 5, 4);
        fetch("n5 w0",  1, 32'h0,  32'hA000_0000, 32'hA000_0000);
        fetch("n5 w3",  1, 32'hC,  32'hA303_0303, 32'hA303_0303);
        fetch("n5 w4",  1, 32'h10, 32'hA404_0404, 32'h0);

        // asynchronous reset in the middle of a word
        start_pulse();
        bytes = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
        send(0, -1);
        #2;
        rst = 0;
        #1;
        status("mid rst", 0, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1;
        start_pulse();
        bytes = '{8'h00, 8'h01};
        push_word(32'hDEAD_BEEF);
        send(0, -1);
        status("after rst", 0, 0, 1, 1, 1);
        fetch("after rst w0", 1, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        fetch("after rst w1", 1, 32'h4, 32'hA101_0101, 32'hA101_0101);

        // gapped stream with a stray ld_start during DATA
        start_pulse();
        bytes = '{8'h00, 8'h02};
        push_word(32'h0102_0304);
        push_word(32'h0506_0708);
        send(1, 4);
        status("gapped", 0, 0, 1, 2, 2);
        fetch("gapped w0", 1, 32'h0, 32'h0102_0304, 32'h0102_0304);
        fetch("gapped w1", 1, 32'h4, 32'h0506_0708, 32'h0506_0708);
        fetch("gapped w2", 1, 32'h8, 32'hA202_0202, 32'hA202_0202);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
